pipe_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Watches decode-stage source registers, the execute-stage destination, the load flag, the branch/jump resolution and the data-memory handshake.
- Drives stall and flush strobes for the PC register and the D/E/M pipeline registers; the D-register flush is the `jb` input of the IF/ID register.
- Replaces ad-hoc per-stage hazard logic with one sequenced FSM.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/hz_load_use_detect.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline control slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam int          REG_X0   = 0;

endpackage

`default_nettype wire

// File: rtl/hz_load_use_detect.sv
// ============================================================================
// Module   : hz_load_use_detect
// Brief    : Combinational load-use hazard comparator (x0 never hazards).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hz_load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_is_load_i,
    output logic              lu_hit_o
);

    logic w_rd_live;
    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rd_live   = (ex_rd_i != REG_AW'(REG_X0));
    assign w_rs1_match = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign w_rs2_match = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign lu_hit_o    = ex_is_load_i && w_rd_live && (w_rs1_match || w_rs2_match);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline. Optional
//            performance counters enabled by macro HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_CYCLES = 1,
    parameter int REG_AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_jb,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              d_stall,
    output logic              d_flush,
    output logic              e_stall,
    output logic              e_flush,
    output logic              m_stall,
    output logic              busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       lu_bubble_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       memwait_cnt
`endif
);

    localparam logic [1:0] LU_RELOAD = 2'(LU_CYCLES - 1);

    hz_state_t  state_q, state_d;
    hz_state_t  ret_q, ret_d;
    hz_state_t  w_eff;
    logic [1:0] lu_cnt_q, lu_cnt_d;

    logic w_mem_hold;
    logic w_lu_hit;
    logic w_pc_stall, w_d_stall, w_d_flush;
    logic w_e_stall, w_e_flush, w_m_stall;

    assign w_mem_hold = mem_req && !mem_ready;

    hz_load_use_detect #(
        .REG_AW       (REG_AW)
    ) u_lu_detect (
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .ex_rd_i      (ex_rd),
        .ex_is_load_i (ex_is_load),
        .lu_hit_o     (w_lu_hit)
    );

    // The cycle mem_hold drops, MEM_WAIT acts as the state it interrupted so
    // the pipeline never sees an unguarded gap between wait and resumption.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        lu_cnt_d   = lu_cnt_q;
        w_pc_stall = 1'b0;
        w_d_stall  = 1'b0;
        w_d_flush  = 1'b0;
        w_e_stall  = 1'b0;
        w_e_flush  = 1'b0;
        w_m_stall  = 1'b0;
        w_eff      = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (w_mem_hold) begin
            w_pc_stall = 1'b1;
            w_d_stall  = 1'b1;
            w_e_stall  = 1'b1;
            w_m_stall  = 1'b1;
            if (state_q != MEM_WAIT) begin
                ret_d = state_q;
            end
            state_d = MEM_WAIT;
        end else begin
            state_d = w_eff;
            case (w_eff)
                LU_STALL: begin
                    w_pc_stall = 1'b1;
                    w_d_stall  = 1'b1;
                    w_e_flush  = 1'b1;
                    lu_cnt_d   = lu_cnt_q - 2'd1;
                    if (lu_cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (ex_jb) begin
                        w_d_flush = 1'b1;
                        w_e_flush = 1'b1;
                    end else if (w_lu_hit) begin
                        w_pc_stall = 1'b1;
                        w_d_stall  = 1'b1;
                        w_e_flush  = 1'b1;
                        if (LU_CYCLES > 1) begin
                            lu_cnt_d = LU_RELOAD;
                            state_d  = LU_STALL;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            lu_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    assign pc_stall = w_pc_stall && !rst;
    assign d_stall  = w_d_stall  && !rst;
    assign d_flush  = w_d_flush  && !rst;
    assign e_stall  = w_e_stall  && !rst;
    assign e_flush  = w_e_flush  && !rst;
    assign m_stall  = w_m_stall  && !rst;
    assign busy     = (state_q != RUN) && !rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_bubble_q;
    logic [31:0] flush_q;
    logic [31:0] memwait_q;

    // A load-use bubble is any E flush not caused by a branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_bubble_q <= 32'd0;
            flush_q     <= 32'd0;
            memwait_q   <= 32'd0;
        end else begin
            if (w_e_flush && !w_d_flush && (lu_bubble_q != 32'hFFFF_FFFF)) begin
                lu_bubble_q <= lu_bubble_q + 32'd1;
            end
            if (w_d_flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
            if (w_mem_hold && (memwait_q != 32'hFFFF_FFFF)) begin
                memwait_q <= memwait_q + 32'd1;
            end
        end
    end

    assign lu_bubble_cnt = lu_bubble_q;
    assign flush_cnt     = flush_q;
    assign memwait_cnt   = memwait_q;
`endif

endmodule

`default_nettype wire
